// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: debounced buttons, cursor, turn/mark FSM, win/draw detection
// and frame-synchronised display registers for the VGA graphics block.
module ttt_game_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_place,
  input  logic        btn_restart,
  input  logic        frame_tick,
  output logic [17:0] board,
  output logic [8:0]  cell_select_flag,
  output logic [1:0]  game_state,
  output logic [1:0]  winner,
  output logic        turn,
  output logic        move_err
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam int B_RIGHT   = 0;
  localparam int B_LEFT    = 1;
  localparam int B_DOWN    = 2;
  localparam int B_UP      = 3;
  localparam int B_PLACE   = 4;
  localparam int B_RESTART = 5;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_CHECK = 2'b01,
    ST_WIN   = 2'b10,
    ST_DRAW  = 2'b11
  } state_t;

  logic [5:0]  raw_s;
  logic [5:0]  pulse_s;
  state_t      state_r;
  logic [17:0] board_r;
  logic [3:0]  cursor_r;
  logic [1:0]  winner_r;
  logic        turn_r;
  logic        move_err_r;
  logic [4:0]  cur_x2_s;
  logic [1:0]  cell_s;
  logic [1:0]  mark_s;

  assign raw_s = {btn_restart, btn_place, btn_up, btn_down, btn_left, btn_right};

  // Per-button synchroniser, stability counter and rising-edge pulse.
  for (genvar g = 0; g < 6; g++) begin : g_db
    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             level_d_r;
    logic             pulse_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise, debounce and edge-detect one raw button.
    always_ff @(posedge clk25 or negedge reset) begin
      if (!reset) begin
        sync1_r   <= 1'b0;
        sync2_r   <= 1'b0;
        level_r   <= 1'b0;
        level_d_r <= 1'b0;
        pulse_r   <= 1'b0;
        cnt_r     <= {CNT_W{1'b0}};
      end else begin
        sync1_r   <= raw_s[g];
        sync2_r   <= sync1_r;
        level_d_r <= level_r;
        pulse_r   <= level_r & ~level_d_r;
        if (sync2_r == level_r) begin
          cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
          cnt_r   <= {CNT_W{1'b0}};
          level_r <= ~level_r;
        end else begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end

    assign pulse_s[g] = pulse_r;
  end

  function automatic logic [3:0] cur_up(input logic [3:0] c);
    return (c >= 4'd3) ? (c - 4'd3) : (c + 4'd6);
  endfunction

  function automatic logic [3:0] cur_down(input logic [3:0] c);
    return (c < 4'd6) ? (c + 4'd3) : (c - 4'd6);
  endfunction

  function automatic logic [3:0] cur_left(input logic [3:0] c);
    logic [3:0] n;
    case (c)
      4'd0, 4'd3, 4'd6: n = c + 4'd2;
      default:          n = c - 4'd1;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] cur_right(input logic [3:0] c);
    logic [3:0] n;
    case (c)
      4'd2, 4'd5, 4'd8: n = c - 4'd2;
      default:          n = c + 4'd1;
    endcase
    return n;
  endfunction

  function automatic logic line_win(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] own;
    for (int i = 0; i < 9; i++) begin
      own[i] = (b[2*i +: 2] == m);
    end
    return (own[0] & own[1] & own[2]) | (own[3] & own[4] & own[5]) |
           (own[6] & own[7] & own[8]) | (own[0] & own[3] & own[6]) |
           (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
           (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
  endfunction

  function automatic logic board_full(input logic [17:0] b);
    logic full;
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      full = full & (|b[2*i +: 2]);
    end
    return full;
  endfunction

  function automatic logic [1:0] state_code(input state_t s);
    logic [1:0] code;
    case (s)
      ST_WIN:  code = 2'b10;
      ST_DRAW: code = 2'b11;
      default: code = 2'b00;
    endcase
    return code;
  endfunction

  // Cursor cell contents and the mark of the player to move.
  always_comb begin
    cur_x2_s = {cursor_r, 1'b0};
    cell_s   = board_r[cur_x2_s +: 2];
    if (turn_r) begin
      mark_s = 2'b10;
    end else begin
      mark_s = 2'b01;
    end
  end

  // Game FSM; restart outranks every other pulse, then place, up, down, left, right.
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_PLAY;
      board_r    <= 18'd0;
      cursor_r   <= 4'd4;
      winner_r   <= 2'b00;
      turn_r     <= 1'b0;
      move_err_r <= 1'b0;
    end else begin
      move_err_r <= 1'b0;
      if (pulse_s[B_RESTART]) begin
        state_r  <= ST_PLAY;
        board_r  <= 18'd0;
        cursor_r <= 4'd4;
        winner_r <= 2'b00;
        turn_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_PLAY: begin
            if (pulse_s[B_PLACE]) begin
              if (cell_s == 2'b00) begin
                board_r[cur_x2_s +: 2] <= mark_s;
                state_r                <= ST_CHECK;
              end else begin
                move_err_r <= 1'b1;
              end
            end else if (pulse_s[B_UP]) begin
              cursor_r <= cur_up(cursor_r);
            end else if (pulse_s[B_DOWN]) begin
              cursor_r <= cur_down(cursor_r);
            end else if (pulse_s[B_LEFT]) begin
              cursor_r <= cur_left(cursor_r);
            end else if (pulse_s[B_RIGHT]) begin
              cursor_r <= cur_right(cursor_r);
            end
          end
          ST_CHECK: begin
            if (line_win(board_r, mark_s)) begin
              state_r  <= ST_WIN;
              winner_r <= mark_s;
            end else if (board_full(board_r)) begin
              state_r <= ST_DRAW;
            end else begin
              turn_r  <= ~turn_r;
              state_r <= ST_PLAY;
            end
          end
          ST_WIN, ST_DRAW: begin
            if (pulse_s[B_PLACE]) begin
              move_err_r <= 1'b1;
            end
          end
          default: state_r <= ST_PLAY;
        endcase
      end
    end
  end

  // Display registers refresh only at vertical blanking so a frame never tears.
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      board            <= 18'd0;
      cell_select_flag <= 9'b000010000;
      game_state       <= 2'b00;
      winner           <= 2'b00;
    end else if (frame_tick) begin
      board            <= board_r;
      cell_select_flag <= 9'(9'b000000001 << cursor_r);
      game_state       <= state_code(state_r);
      winner           <= winner_r;
    end
  end

  assign turn     = turn_r;
  assign move_err = move_err_r;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed self-checking bench for ttt_game_ctrl with a short debounce window.
module tb_ttt_game_ctrl;

  logic        clk25 = 1'b0;
  logic        reset;
  logic        btn_up, btn_down, btn_left, btn_right, btn_place, btn_restart;
  logic        frame_tick;
  logic [17:0] board;
  logic [8:0]  cell_select_flag;
  logic [1:0]  game_state;
  logic [1:0]  winner;
  logic        turn;
  logic        move_err;

  int total = 0;
  int bad   = 0;
  int cur   = 4;

  ttt_game_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk25(clk25), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_place(btn_place), .btn_restart(btn_restart), .frame_tick(frame_tick),
    .board(board), .cell_select_flag(cell_select_flag), .game_state(game_state),
    .winner(winner), .turn(turn), .move_err(move_err)
  );

  always #20 clk25 = ~clk25;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk25);
    frame_tick = 1'b0;
  endtask

  // 0 right, 1 left, 2 down, 3 up, 4 place, 5 restart
  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_right = v;
      1: btn_left = v;
      2: btn_down = v;
      3: btn_up = v;
      4: btn_place = v;
      default: btn_restart = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    cycles(10);
    set_btn(which, 1'b0);
    cycles(10);
  endtask

  task automatic goto_cell(input int target);
    while ((cur / 3) != (target / 3)) begin
      press(2);
      cur = (cur < 6) ? cur + 3 : cur - 6;
    end
    while ((cur % 3) != (target % 3)) begin
      press(0);
      cur = ((cur % 3) == 2) ? cur - 2 : cur + 1;
    end
  endtask

  task automatic place_count_err(output int n);
    n = 0;
    btn_place = 1'b1;
    repeat (12) begin
      @(negedge clk25);
      if (move_err) n++;
    end
    btn_place = 1'b0;
    cycles(10);
  endtask

  task automatic restart_game();
    press(5);
    cur = 4;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    {btn_up, btn_down, btn_left, btn_right, btn_place, btn_restart} = 6'b000000;
    frame_tick = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(2);
    tick();
    total++; if (board !== 18'h00000) begin bad++; $display("FAIL reset_board got=%h exp=%h", board, 18'h00000); end
    total++; if (cell_select_flag !== 9'h010) begin bad++; $display("FAIL reset_cursor got=%h exp=%h", cell_select_flag, 9'h010); end
    total++; if (game_state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", game_state); end
    total++; if (winner !== 2'b00) begin bad++; $display("FAIL reset_winner got=%b exp=00", winner); end
    total++; if (turn !== 1'b0 || move_err !== 1'b0) begin bad++; $display("FAIL reset_turn_err got=%b%b exp=00", turn, move_err); end
  endtask

  task automatic test_cursor();
    // Raw rise just before edge 1: pulse after edge 7, cursor after edge 8.
    btn_right = 1'b1;
    cycles(7);
    tick();
    total++; if (cell_select_flag !== 9'h010) begin bad++; $display("FAIL right_latency_early got=%h exp=%h", cell_select_flag, 9'h010); end
    tick();
    total++; if (cell_select_flag !== 9'h020) begin bad++; $display("FAIL right_latency got=%h exp=%h", cell_select_flag, 9'h020); end
    btn_right = 1'b0;
    cycles(10);
    press(0);
    tick();
    total++; if (cell_select_flag !== 9'h008) begin bad++; $display("FAIL right_row_wrap got=%h exp=%h", cell_select_flag, 9'h008); end
    btn_right = 1'b1;
    cycles(3);
    btn_right = 1'b0;
    cycles(12);
    tick();
    total++; if (cell_select_flag !== 9'h008) begin bad++; $display("FAIL glitch got=%h exp=%h", cell_select_flag, 9'h008); end
    press(3);
    tick();
    total++; if (cell_select_flag !== 9'h001) begin bad++; $display("FAIL up got=%h exp=%h", cell_select_flag, 9'h001); end
    press(3);
    tick();
    total++; if (cell_select_flag !== 9'h040) begin bad++; $display("FAIL up_col_wrap got=%h exp=%h", cell_select_flag, 9'h040); end
    cur = 6;
  endtask

  task automatic test_win();
    int cells[5] = '{0, 3, 1, 4, 2};
    logic turns[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int n;
    restart_game();
    for (int i = 0; i < 5; i++) begin
      goto_cell(cells[i]);
      press(4);
      total++; if (turn !== turns[i]) begin bad++; $display("FAIL win_turn%0d got=%b exp=%b", i, turn, turns[i]); end
      if (i == 3) tick();
    end
    total++; if (board !== 18'h00285 || game_state !== 2'b00) begin bad++; $display("FAIL frame_hold got=%h/%b exp=%h/00", board, game_state, 18'h00285); end
    tick();
    total++; if (board !== 18'h00295) begin bad++; $display("FAIL win_board got=%h exp=%h", board, 18'h00295); end
    total++; if (game_state !== 2'b10 || winner !== 2'b01) begin bad++; $display("FAIL win_state got=%b/%b exp=10/01", game_state, winner); end
    place_count_err(n);
    tick();
    total++; if (n !== 1) begin bad++; $display("FAIL win_place_err got=%0d exp=1", n); end
    total++; if (board !== 18'h00295) begin bad++; $display("FAIL win_board_kept got=%h exp=%h", board, 18'h00295); end
    btn_restart = 1'b1;
    btn_place = 1'b1;
    cycles(10);
    btn_restart = 1'b0;
    btn_place = 1'b0;
    cycles(10);
    cur = 4;
    total++; if (board !== 18'h00295) begin bad++; $display("FAIL restart_pre_tick got=%h exp=%h", board, 18'h00295); end
    tick();
    total++; if (board !== 18'h00000 || game_state !== 2'b00 || cell_select_flag !== 9'h010) begin
      bad++; $display("FAIL restart_place got=%h/%b/%h exp=00000/00/010", board, game_state, cell_select_flag); end
    total++; if (winner !== 2'b00 || turn !== 1'b0) begin bad++; $display("FAIL restart_winner got=%b/%b exp=00/0", winner, turn); end
  endtask

  task automatic test_occupied();
    int n;
    press(4);
    total++; if (turn !== 1'b1) begin bad++; $display("FAIL occ_first_turn got=%b exp=1", turn); end
    place_count_err(n);
    total++; if (n !== 1) begin bad++; $display("FAIL occ_err got=%0d exp=1", n); end
    total++; if (turn !== 1'b1) begin bad++; $display("FAIL occ_turn got=%b exp=1", turn); end
    tick();
    total++; if (board[9:8] !== 2'b01 || board !== 18'h00100) begin bad++; $display("FAIL occ_board got=%h exp=%h", board, 18'h00100); end
  endtask

  task automatic test_draw();
    int cells[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    logic turns[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    restart_game();
    for (int i = 0; i < 9; i++) begin
      goto_cell(cells[i]);
      press(4);
      total++; if (turn !== turns[i]) begin bad++; $display("FAIL draw_turn%0d got=%b exp=%b", i, turn, turns[i]); end
    end
    tick();
    total++; if (game_state !== 2'b11 || winner !== 2'b00) begin bad++; $display("FAIL draw_state got=%b/%b exp=11/00", game_state, winner); end
    total++; if (board !== 18'h16A59) begin bad++; $display("FAIL draw_board got=%h exp=%h", board, 18'h16A59); end
    for (int i = 0; i < 9; i++) begin
      total++; if (board[2*i +: 2] === 2'b00) begin bad++; $display("FAIL draw_cell%0d got=00 exp=nonempty", i); end
    end
  endtask

  task automatic test_reset_mid();
    btn_right = 1'b1;
    cycles(3);
    reset = 1'b0;
    #1;
    total++; if (board !== 18'h00000 || game_state !== 2'b00 || winner !== 2'b00) begin
      bad++; $display("FAIL mid_reset_disp got=%h/%b/%b exp=00000/00/00", board, game_state, winner); end
    total++; if (cell_select_flag !== 9'h010 || turn !== 1'b0 || move_err !== 1'b0) begin
      bad++; $display("FAIL mid_reset_cur got=%h/%b/%b exp=010/0/0", cell_select_flag, turn, move_err); end
    cycles(2);
    btn_right = 1'b0;
    reset = 1'b1;
    cycles(12);
    tick();
    total++; if (cell_select_flag !== 9'h010 || board !== 18'h00000) begin
      bad++; $display("FAIL mid_reset_after got=%h/%h exp=010/00000", cell_select_flag, board); end
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_win();
    test_occupied();
    test_draw();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
